// File: rtl/serial_seq_detector_pkg.sv
// rtl/serial_seq_detector_pkg.sv - shared types and constants for the 1011 sequence detector
package serial_seq_detector_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/serial_seq_detector_if.sv
// rtl/serial_seq_detector_if.sv - serial bit input, counter control and detector status bundle
import serial_seq_detector_pkg::*;

interface serial_seq_detector_if #(
  parameter int CNT_W = 8
);
  logic               bit_in;
  logic               bit_valid;
  logic               clear_count;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [STATE_W-1:0] state_out;

  modport master (
    output bit_in, bit_valid, clear_count,
    input  match, match_count, state_out
  );

  modport slave (
    input  bit_in, bit_valid, clear_count,
    output match, match_count, state_out
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, clear wins over increment
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/serial_seq_detector.sv
// rtl/serial_seq_detector.sv - Moore FSM detecting 1011 on a gated serial stream
// with a registered match pulse and a saturating match counter.
import serial_seq_detector_pkg::*;

module serial_seq_detector #(
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  serial_seq_detector_if.slave bus
);

  state_t state;
  state_t nxt;
  logic   legal;
  logic   enter;
  logic   match_r;

  always_comb begin
    nxt   = S0;
    legal = 1'b1;
    case (state)
      S0:      nxt = (bus.bit_in == PATTERN[3]) ? S1    : S0;
      S1:      nxt = (bus.bit_in == PATTERN[2]) ? S10   : S1;
      S10:     nxt = (bus.bit_in == PATTERN[1]) ? S101  : S0;
      S101:    nxt = (bus.bit_in == PATTERN[0]) ? S1011 : S10;
      S1011:   nxt = bus.bit_in ? S1 : (OVERLAP ? S10 : S0);
      default: begin
        nxt   = S0;
        legal = 1'b0;
      end
    endcase
    // Unused encodings recover to S0 even without a valid bit.
    if (legal && !bus.bit_valid) begin
      nxt = state;
    end
  end

  assign enter = (nxt == S1011) && (state != S1011);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S0;
      match_r <= 1'b0;
    end else begin
      state   <= nxt;
      match_r <= enter;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (enter),
    .clr   (bus.clear_count),
    .count (bus.match_count)
  );

  assign bus.match     = match_r;
  assign bus.state_out = state;

endmodule

// File: tb/tb_serial_seq_detector.sv
// tb/tb_serial_seq_detector.sv - scoreboard bench driving an overlapping 2-bit-count
// detector and a non-overlapping 8-bit-count detector with the same stream.
module tb_serial_seq_detector;

  logic clk;
  logic reset;
  logic bit_in;
  logic bit_valid;
  logic clear_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ma;
    logic [1:0] ca;
    logic [2:0] sa;
    logic       mb;
    logic [7:0] cb;
    logic [2:0] sb;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  serial_seq_detector_if #(.CNT_W(2)) if_a ();
  serial_seq_detector_if #(.CNT_W(8)) if_b ();

  assign if_a.bit_in      = bit_in;
  assign if_a.bit_valid   = bit_valid;
  assign if_a.clear_count = clear_count;
  assign if_b.bit_in      = bit_in;
  assign if_b.bit_valid   = bit_valid;
  assign if_b.clear_count = clear_count;

  serial_seq_detector #(.CNT_W(2), .OVERLAP(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  serial_seq_detector #(.CNT_W(8), .OVERLAP(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic c,
                      input logic ma, input logic [1:0] ca, input logic [2:0] sa,
                      input logic mb, input logic [7:0] cb, input logic [2:0] sb,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset       = r;
    bit_in      = b;
    bit_valid   = v;
    clear_count = c;
    e.ma = ma; e.ca = ca; e.sa = sa;
    e.mb = mb; e.cb = cb; e.sb = sb;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per sampled edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, " match_a"}, 8'(if_a.match),       8'(e.ma));
        chk({e.tag, " count_a"}, 8'(if_a.match_count), 8'(e.ca));
        chk({e.tag, " state_a"}, 8'(if_a.state_out),   8'(e.sa));
        chk({e.tag, " match_b"}, 8'(if_b.match),       8'(e.mb));
        chk({e.tag, " count_b"}, if_b.match_count,     e.cb);
        chk({e.tag, " state_b"}, 8'(if_b.state_out),   8'(e.sb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] ca_prev;
    logic [1:0] ca_new;
    logic [7:0] cb_prev;
    reset       = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    clear_count = 1'b0;

    // Reset held with valid toggling bits
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "rst1");

    // Stream 1011011: overlap gives two pulses, no-overlap gives one
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, "ov_b1");
    step(0, 0, 1, 0, 0, 0, 2, 0, 0, 2, "ov_b2");
    step(0, 1, 1, 0, 0, 0, 3, 0, 0, 3, "ov_b3");
    step(0, 1, 1, 0, 1, 1, 4, 1, 1, 4, "ov_b4");
    step(0, 0, 1, 0, 0, 1, 2, 0, 1, 0, "ov_b5");
    step(0, 1, 1, 0, 0, 1, 3, 0, 1, 1, "ov_b6");
    step(0, 1, 1, 0, 1, 2, 4, 0, 1, 1, "ov_b7");
    step(0, 0, 0, 0, 0, 2, 4, 0, 1, 1, "ov_idle");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst2");

    // Valid gating: 101, five invalid cycles, then valid 1
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, "vg_b1");
    step(0, 0, 1, 0, 0, 0, 2, 0, 0, 2, "vg_b2");
    step(0, 1, 1, 0, 0, 0, 3, 0, 0, 3, "vg_b3");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 3, 0, 0, 3, "vg_gap");
    step(0, 1, 1, 0, 1, 1, 4, 1, 1, 4, "vg_b4");
    step(0, 0, 0, 0, 0, 1, 4, 0, 1, 4, "vg_hold");

    // Four more matches: 2-bit counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      ca_prev = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
      ca_new  = (k + 2 > 3) ? 2'd3 : 2'(k + 2);
      cb_prev = 8'(k + 1);
      step(0, 1, 1, 0, 0, ca_prev, 1, 0, cb_prev, 1, "sat_b1");
      step(0, 0, 1, 0, 0, ca_prev, 2, 0, cb_prev, 2, "sat_b2");
      step(0, 1, 1, 0, 0, ca_prev, 3, 0, cb_prev, 3, "sat_b3");
      step(0, 1, 1, 0, 1, ca_new,  4, 1, cb_prev + 8'd1, 4, "sat_b4");
    end

    // Clear coincident with a match edge
    step(0, 1, 1, 0, 0, 3, 1, 0, 5, 1, "clr_b1");
    step(0, 0, 1, 0, 0, 3, 2, 0, 5, 2, "clr_b2");
    step(0, 1, 1, 0, 0, 3, 3, 0, 5, 3, "clr_b3");
    step(0, 1, 1, 1, 1, 0, 4, 1, 0, 4, "clr_b4");
    step(0, 0, 0, 0, 0, 0, 4, 0, 0, 4, "clr_idle");

    // Reset mid-pattern discards the 101 prefix
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, "mid_b1");
    step(0, 0, 1, 0, 0, 0, 2, 0, 0, 2, "mid_b2");
    step(0, 1, 1, 0, 0, 0, 3, 0, 0, 3, "mid_b3");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst state_a", 8'(if_a.state_out), 8'd0);
    chk("async_rst state_b", 8'(if_b.state_out), 8'd0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "mid_rst");
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, "mid_b4");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "mid_hold");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drain", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_seq_detector.md
# serial_seq_detector

Consumes the registered serial bit stream produced by the D flip-flop stage (its `q` output) and detects the bit pattern 1011 (first-received bit first), with optional overlap. Each detection produces a one-cycle `match` pulse and increments a saturating match counter, which software or a downstream stage can clear. It sits directly downstream of the flip-flop stage in the same clock domain.

## Interface
- `CNT_W`, 8 — width of the match counter.
- `OVERLAP`, 1 — 1: the trailing bits of a match may start the next match; 0: detection restarts from scratch after a match.
- `clk` input 1 — clock, rising-edge.
- `reset` input 1 — asynchronous, active-high reset.
- `bit_in` input 1 — serial data bit (the `q` output of the upstream flip-flop).
- `bit_valid` input 1 — `bit_in` is consumed on a rising edge only while this is high.
- `clear_count` input 1 — synchronous clear of `match_count`.
- `match` output 1 — registered one-cycle pulse marking a detected pattern.
- `match_count` output CNT_W — number of matches since reset or the last clear; saturates.
- `state_out` output 3 — current FSM state encoding, for debug.

## Operation
- Moore FSM with 5 states:
  - S0: idle, no prefix.
  - S1: seen "1".
  - S10: seen "10".
  - S101: seen "101".
  - S1011: pattern complete.
- Transitions occur only on an edge with `bit_valid`=1. Otherwise the state holds.
- Transitions for input 0 / input 1:
  - S0: 0→S0, 1→S1.
  - S1: 0→S10, 1→S1.
  - S10: 0→S0, 1→S101.
  - S101: 0→S10, 1→S1011.
  - S1011 with OVERLAP=1: 0→S10, 1→S1.
  - S1011 with OVERLAP=0: 0→S0, 1→S1.
- `match` is set to 1 on the edge that enters S1011. It is cleared on every other edge, including edges where the state holds at S1011 because `bit_valid`=0.
- `match_count` increments by 1 on the same edge that sets `match`.
  - At all-ones the counter holds (saturates); it does not wrap.
- `clear_count` has priority over an increment. On a simultaneous clear and match, the count becomes 0 and the match is not counted, but `match` still pulses.
- The FSM never reaches an illegal state. Any unused encoding returns to S0 on the next edge, regardless of `bit_valid`.

## Timing
- Reset values: state S0, `match`=0, `match_count`=0, `state_out`=3'd0.
- Reset takes effect immediately (asynchronously). The first transition can occur on the first rising edge after `reset` is deasserted.
- Latency: `match` is high during the cycle after the edge that samples the final "1" of the pattern.
  - `match_count` shows the new value during that same cycle.
- Minimum spacing between `match` pulses with continuous valid bits:
  - OVERLAP=1: 3 cycles (stream 1011011 gives pulses at bits 4 and 7).
  - OVERLAP=0: 4 cycles.
- Reset asserted mid-pattern discards the partial prefix; the pattern must be presented again from scratch.
- `bit_in` must be stable around the rising edge. The upstream flip-flop guarantees this because both stages share `clk`.

## Structure
- Package `serial_seq_detector_pkg` contains:
  - the state enum: S0=0, S1=1, S10=2, S101=3, S1011=4;
  - the pattern constant 4'b1011;
  - the state width (3).
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `reset`, `inc`, `clr`, `count`) implements the saturating counter with clear priority.
- The top level holds the FSM next-state logic, the state register, and the `match` register.

## Test plan
- Reset behaviour: assert `reset` for 20 ns with `bit_valid`=1 and `bit_in` toggling → `match`=0, `match_count`=0, `state_out`=0 throughout.
- Overlap: OVERLAP=1, stream 1,0,1,1,0,1,1 with continuous valid → `match` pulses after bit 4 and after bit 7; `match_count`=2.
- No overlap: OVERLAP=0, same stream → single pulse after bit 4; `match_count`=1; `state_out` after bit 7 is S1.
- Valid gating: stream 1,0,1 then `bit_valid`=0 for 5 cycles with `bit_in`=0, then valid bit 1 → exactly one `match` pulse, and only after the final valid bit; state holds at S101 during the gap.
- Saturation and clear: CNT_W=2, feed 5 matches → `match_count` holds at 3.
  - Assert `clear_count` on the cycle of a match edge → count becomes 0 while `match`=1.
- Reset mid-pattern: feed 1,0,1, assert `reset`, release, feed 1 → no match; `state_out`=S1.
